// File: rtl/rv_iopmp_dl_multicycle.sv
// rtl/rv_iopmp_dl_multicycle.sv - windowed multi-cycle IOPMP decision logic
package rv_iopmp_pkg;

    typedef enum logic [2:0] {
        ACCESS_NONE      = 3'b000,
        ACCESS_READ      = 3'b001,
        ACCESS_WRITE     = 3'b010,
        ACCESS_EXECUTION = 3'b100
    } access_t;

    typedef struct packed {
        logic [30:0] md;
        logic        l;
    } srcmd_en_t;

    typedef struct packed {
        logic [31:0] enh;
        srcmd_en_t   en;
    } srcmd_entry_t;

    typedef struct packed {
        logic [15:0] t;
    } mdcfg_entry_t;

endpackage

module rv_iopmp_dl_multicycle #(
    parameter int SID_WIDTH              = 8,
    parameter int NUMBER_MDS             = 2,
    parameter int NUMBER_ENTRIES         = 8,
    parameter int NUMBER_MASTERS         = 2,
    parameter int NUMBER_ENTRY_ANALYZERS = 4
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic                                             enable_i,
    input  logic                                             req_valid_i,
    output logic                                             req_ready_o,
    input  logic [SID_WIDTH-1:0]                             sid_i,
    input  rv_iopmp_pkg::access_t                            access_type_i,
    input  logic [15:0]                                      prio_entry_i,
    input  rv_iopmp_pkg::srcmd_entry_t [NUMBER_MASTERS-1:0]  srcmd_table_i,
    input  rv_iopmp_pkg::mdcfg_entry_t [NUMBER_MDS-1:0]      mdcfg_table_i,
    output logic [15:0]                                      entry_offset_o,
    input  logic [NUMBER_ENTRY_ANALYZERS-1:0]                entry_match_i,
    input  logic [NUMBER_ENTRY_ANALYZERS-1:0]                entry_allow_i,
    output logic                                             rsp_valid_o,
    input  logic                                             rsp_ready_i,
    output logic                                             allow_o,
    output logic                                             err_o,
    output logic [2:0]                                       err_type_o,
    output logic [15:0]                                      err_entry_index_o
);

    localparam int N = NUMBER_ENTRY_ANALYZERS;
    localparam logic [16:0] NUM_ENTRIES_W = 17'(NUMBER_ENTRIES);
    localparam logic [16:0] WIN_W         = 17'(N);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t                 state_q, state_d;
    logic [SID_WIDTH-1:0]   sid_q, sid_d;
    rv_iopmp_pkg::access_t  access_q, access_d;
    logic [15:0]            prio_q, prio_d;
    logic [15:0]            offset_q, offset_d;
    logic                   allow_seen_q, allow_seen_d;
    logic                   deny_seen_q, deny_seen_d;
    logic [15:0]            deny_idx_q, deny_idx_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   allow_q, allow_d;
    logic                   err_q, err_d;
    logic [2:0]             err_type_q, err_type_d;
    logic [15:0]            err_idx_q, err_idx_d;

    logic [62:0]            md_all;
    logic [N-1:0][16:0]     win_idx;
    logic [N-1:0]           eligible;
    logic [16:0]            md_lo;
    logic                   owned;
    logic                   e_found, e_allow;
    logic [16:0]            e_idx;
    logic                   np_allow, np_deny_found;
    logic [16:0]            np_deny_idx;
    logic                   last_window;
    logic                   allow_seen_nxt;
    logic                   unused_sink;

    function automatic logic [2:0] access_code(rv_iopmp_pkg::access_t a);
        case (a)
            rv_iopmp_pkg::ACCESS_READ:      return 3'd1;
            rv_iopmp_pkg::ACCESS_WRITE:     return 3'd2;
            rv_iopmp_pkg::ACCESS_EXECUTION: return 3'd3;
            default:                        return 3'd7;
        endcase
    endfunction

    // Ownership and first-match search over the current analyzer window
    always_comb begin
        md_all        = '0;
        eligible      = '0;
        win_idx       = '0;
        md_lo         = '0;
        owned         = 1'b0;
        e_found       = 1'b0;
        e_allow       = 1'b0;
        e_idx         = '0;
        np_allow      = 1'b0;
        np_deny_found = 1'b0;
        np_deny_idx   = '0;
        for (int m = 0; m < NUMBER_MASTERS; m++) begin
            if (sid_q == SID_WIDTH'(m)) begin
                md_all = {srcmd_table_i[m].enh, srcmd_table_i[m].en.md};
            end
        end
        for (int j = 0; j < N; j++) begin
            win_idx[j] = {1'b0, offset_q} + 17'(j);
            owned = 1'b0;
            md_lo = '0;
            for (int k = 0; k < NUMBER_MDS; k++) begin
                if (win_idx[j] >= md_lo && win_idx[j] < {1'b0, mdcfg_table_i[k].t} && md_all[k]) begin
                    owned = 1'b1;
                end
                md_lo = {1'b0, mdcfg_table_i[k].t};
            end
            eligible[j] = entry_match_i[j] && (win_idx[j] < NUM_ENTRIES_W) && owned;
        end
        for (int j = 0; j < N; j++) begin
            if (eligible[j]) begin
                if (!e_found) begin
                    e_found = 1'b1;
                    e_idx   = win_idx[j];
                    e_allow = entry_allow_i[j];
                end
                if (win_idx[j] >= {1'b0, prio_q}) begin
                    if (entry_allow_i[j]) begin
                        np_allow = 1'b1;
                    end else if (!np_deny_found) begin
                        np_deny_found = 1'b1;
                        np_deny_idx   = win_idx[j];
                    end
                end
            end
        end
    end

    assign last_window = ({1'b0, offset_q} + WIN_W) >= NUM_ENTRIES_W;

    always_comb begin
        state_d        = state_q;
        sid_d          = sid_q;
        access_d       = access_q;
        prio_d         = prio_q;
        offset_d       = offset_q;
        allow_seen_d   = allow_seen_q;
        deny_seen_d    = deny_seen_q;
        deny_idx_d     = deny_idx_q;
        rsp_valid_d    = rsp_valid_q;
        allow_d        = allow_q;
        err_d          = err_q;
        err_type_d     = err_type_q;
        err_idx_d      = err_idx_q;
        allow_seen_nxt = allow_seen_q | np_allow;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    sid_d        = sid_i;
                    access_d     = access_type_i;
                    prio_d       = prio_entry_i;
                    offset_d     = '0;
                    allow_seen_d = 1'b0;
                    deny_seen_d  = 1'b0;
                    deny_idx_d   = '0;
                    if (!enable_i) begin
                        {allow_d, err_d, err_type_d, err_idx_d} = {1'b1, 1'b0, 3'd0, 16'd0};
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else if (32'(sid_i) >= NUMBER_MASTERS) begin
                        {allow_d, err_d, err_type_d, err_idx_d} = {1'b0, 1'b1, 3'd6, 16'd0};
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (e_found && e_idx < {1'b0, prio_q}) begin
                    if (e_allow) begin
                        {allow_d, err_d, err_type_d, err_idx_d} = {1'b1, 1'b0, 3'd0, 16'd0};
                    end else begin
                        {allow_d, err_d, err_type_d, err_idx_d} =
                            {1'b0, 1'b1, access_code(access_q), e_idx[15:0]};
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    allow_seen_d = allow_seen_nxt;
                    if (!deny_seen_q && np_deny_found) begin
                        deny_seen_d = 1'b1;
                        deny_idx_d  = np_deny_idx[15:0];
                    end
                    if (allow_seen_nxt) begin
                        {allow_d, err_d, err_type_d, err_idx_d} = {1'b1, 1'b0, 3'd0, 16'd0};
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else if (last_window) begin
                        if (deny_seen_d) begin
                            {allow_d, err_d, err_type_d, err_idx_d} =
                                {1'b0, 1'b1, access_code(access_q), deny_idx_d};
                        end else begin
                            {allow_d, err_d, err_type_d, err_idx_d} = {1'b0, 1'b1, 3'd5, 16'd0};
                        end
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        offset_d = offset_q + 16'(N);
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            sid_q        <= '0;
            access_q     <= rv_iopmp_pkg::ACCESS_NONE;
            prio_q       <= '0;
            offset_q     <= '0;
            allow_seen_q <= 1'b0;
            deny_seen_q  <= 1'b0;
            deny_idx_q   <= '0;
            rsp_valid_q  <= 1'b0;
            allow_q      <= 1'b0;
            err_q        <= 1'b0;
            err_type_q   <= '0;
            err_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            sid_q        <= sid_d;
            access_q     <= access_d;
            prio_q       <= prio_d;
            offset_q     <= offset_d;
            allow_seen_q <= allow_seen_d;
            deny_seen_q  <= deny_seen_d;
            deny_idx_q   <= deny_idx_d;
            rsp_valid_q  <= rsp_valid_d;
            allow_q      <= allow_d;
            err_q        <= err_d;
            err_type_q   <= err_type_d;
            err_idx_q    <= err_idx_d;
        end
    end

    assign req_ready_o       = (state_q == IDLE);
    assign entry_offset_o    = offset_q;
    assign rsp_valid_o       = rsp_valid_q;
    assign allow_o           = allow_q;
    assign err_o             = err_q;
    assign err_type_o        = err_type_q;
    assign err_entry_index_o = err_idx_q;

    // Lock bits and MD enables beyond NUMBER_MDS do not affect the decision
    assign unused_sink = ^{srcmd_table_i, md_all};

endmodule

// File: tb/tb_rv_iopmp_dl_multicycle.sv
// tb/tb_rv_iopmp_dl_multicycle.sv - randomized self-checking bench for rv_iopmp_dl_multicycle
module tb_rv_iopmp_dl_multicycle;

    localparam int NE  = 8;
    localparam int N   = 4;
    localparam int NM  = 2;
    localparam int NMD = 2;
    localparam int SW  = 8;

    logic                                  clk = 1'b0;
    logic                                  rst;
    logic                                  enable;
    logic                                  req_valid;
    logic                                  req_ready;
    logic [SW-1:0]                         sid;
    rv_iopmp_pkg::access_t                 access_type;
    logic [15:0]                           prio_entry;
    rv_iopmp_pkg::srcmd_entry_t [NM-1:0]   srcmd_table;
    rv_iopmp_pkg::mdcfg_entry_t [NMD-1:0]  mdcfg_table;
    logic [15:0]                           entry_offset;
    logic [N-1:0]                          entry_match;
    logic [N-1:0]                          entry_allow;
    logic                                  rsp_valid;
    logic                                  rsp_ready;
    logic                                  allow;
    logic                                  err;
    logic [2:0]                            err_type;
    logic [15:0]                           err_entry_index;

    logic [11:0] m_arr;
    logic [11:0] a_arr;

    int errors = 0;
    int checks = 0;
    int exp_allow, exp_err, exp_type, exp_idx, exp_lat;
    int max_off;

    always #5 clk = ~clk;

    rv_iopmp_dl_multicycle #(
        .SID_WIDTH(SW), .NUMBER_MDS(NMD), .NUMBER_ENTRIES(NE),
        .NUMBER_MASTERS(NM), .NUMBER_ENTRY_ANALYZERS(N)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .sid_i(sid), .access_type_i(access_type), .prio_entry_i(prio_entry),
        .srcmd_table_i(srcmd_table), .mdcfg_table_i(mdcfg_table),
        .entry_offset_o(entry_offset), .entry_match_i(entry_match), .entry_allow_i(entry_allow),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .allow_o(allow), .err_o(err), .err_type_o(err_type), .err_entry_index_o(err_entry_index)
    );

    // Analyzer array stand-in: indices past the table see random garbage
    always_comb begin
        entry_match = '0;
        entry_allow = '0;
        for (int j = 0; j < N; j++) begin
            if (int'(entry_offset) + j < 12) begin
                entry_match[j] = m_arr[int'(entry_offset) + j];
                entry_allow[j] = a_arr[int'(entry_offset) + j];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int acc_code(input rv_iopmp_pkg::access_t a);
        case (a)
            rv_iopmp_pkg::ACCESS_READ:      return 1;
            rv_iopmp_pkg::ACCESS_WRITE:     return 2;
            rv_iopmp_pkg::ACCESS_EXECUTION: return 3;
            default:                        return 7;
        endcase
    endfunction

    // Entries are visited in index order; priority entries always precede non-priority ones
    task automatic model(input int s, input rv_iopmp_pkg::access_t a, input bit en, input int prio);
        bit elig [NE];
        int first, first_allow, lo, t;
        bit owned;
        int last_win;
        last_win = (NE - 1) / N;
        {exp_allow, exp_err, exp_type, exp_idx} = {32'd0, 32'd0, 32'd0, 32'd0};
        if (!en) begin
            exp_allow = 1; exp_lat = 1;
            return;
        end
        if (s >= NM) begin
            exp_err = 1; exp_type = 6; exp_lat = 1;
            return;
        end
        first = -1;
        first_allow = -1;
        for (int i = 0; i < NE; i++) begin
            owned = 1'b0;
            lo = 0;
            for (int k = 0; k < NMD; k++) begin
                t = int'(mdcfg_table[k].t);
                if (i >= lo && i < t && srcmd_table[s].en.md[k]) owned = 1'b1;
                lo = t;
            end
            elig[i] = m_arr[i] && owned;
            if (elig[i] && first < 0) first = i;
            if (elig[i] && a_arr[i] && first_allow < 0) first_allow = i;
        end
        if (first >= 0 && first < prio) begin
            exp_lat = 2 + first / N;
            if (a_arr[first]) exp_allow = 1;
            else begin
                exp_err = 1; exp_type = acc_code(a); exp_idx = first;
            end
        end else if (first_allow >= 0) begin
            exp_allow = 1; exp_lat = 2 + first_allow / N;
        end else if (first >= 0) begin
            exp_err = 1; exp_type = acc_code(a); exp_idx = first; exp_lat = 2 + last_win;
        end else begin
            exp_err = 1; exp_type = 5; exp_lat = 2 + last_win;
        end
    endtask

    task automatic set_common();
        srcmd_table = '0;
        srcmd_table[0].en.md = 31'd1;
        srcmd_table[1].en.md = 31'd2;
        mdcfg_table[0].t = 16'd4;
        mdcfg_table[1].t = 16'd8;
    endtask

    // Called and returns at 1 time unit after a rising edge
    task automatic run_txn(input string tag, input int s, input rv_iopmp_pkg::access_t a,
                           input bit en, input int prio, input int hold);
        int lat;
        logic [2:0] h_type;
        logic [15:0] h_idx;
        logic h_allow, h_err;
        model(s, a, en, prio);
        req_valid   = 1'b1;
        sid         = SW'(s);
        access_type = a;
        enable      = en;
        prio_entry  = 16'(prio);
        chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        sid = SW'($urandom);
        enable = $urandom_range(0, 1) != 0;
        lat = 1;
        max_off = int'(entry_offset);
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (int'(entry_offset) > max_off) max_off = int'(entry_offset);
        end
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " allow"}, 32'(allow), 32'(exp_allow));
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " err_type"}, 32'(err_type), 32'(exp_type));
        chk({tag, " err_idx"}, 32'(err_entry_index), 32'(exp_idx));
        chk({tag, " req_ready resp"}, 32'(req_ready), 32'd0);
        {h_allow, h_err, h_type, h_idx} = {allow, err, err_type, err_entry_index};
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            chk({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
            chk({tag, " hold outputs"}, 32'({allow, err, err_type, err_entry_index}),
                32'({h_allow, h_err, h_type, h_idx}));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid cleared"}, 32'(rsp_valid), 32'd0);
        chk({tag, " req_ready back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        sid = '0; access_type = rv_iopmp_pkg::ACCESS_READ; prio_entry = 16'd8;
        m_arr = '0; a_arr = '0;
        set_common();
        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset offset", 32'(entry_offset), 32'd0);
        chk("reset outputs", 32'({allow, err, err_type, err_entry_index}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        m_arr = 12'h004; a_arr = 12'h004;
        run_txn("sid0_allow", 0, rv_iopmp_pkg::ACCESS_READ, 1'b1, 8, 0);
        chk("sid0_allow offset stays 0", 32'(max_off), 32'd0);

        m_arr = 12'h002; a_arr = 12'h000;
        run_txn("sid0_read_deny", 0, rv_iopmp_pkg::ACCESS_READ, 1'b1, 8, 0);

        m_arr = 12'h004; a_arr = 12'h004;
        run_txn("sid1_nohit", 1, rv_iopmp_pkg::ACCESS_READ, 1'b1, 8, 0);

        m_arr = 12'h060; a_arr = 12'h040;
        run_txn("prio4_np_allow", 1, rv_iopmp_pkg::ACCESS_WRITE, 1'b1, 4, 0);

        m_arr = 12'h020; a_arr = 12'h000;
        run_txn("prio4_np_deny", 1, rv_iopmp_pkg::ACCESS_WRITE, 1'b1, 4, 0);

        run_txn("bad_sid", 2, rv_iopmp_pkg::ACCESS_READ, 1'b1, 8, 0);
        run_txn("bypass", 0, rv_iopmp_pkg::ACCESS_READ, 1'b0, 8, 3);

        m_arr = 12'h004; a_arr = 12'h000;
        req_valid = 1'b1; sid = 8'd1; enable = 1'b1; prio_entry = 16'd8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("scan second window offset", 32'(entry_offset), 32'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort offset", 32'(entry_offset), 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("abort no response", 32'(rsp_valid), 32'd0);
        end

        for (int n = 0; n < 300; n++) begin
            int t0, s, p, hold;
            bit en;
            rv_iopmp_pkg::access_t a;
            t0 = $urandom_range(0, 8);
            mdcfg_table[0].t = 16'(t0);
            mdcfg_table[1].t = 16'($urandom_range(t0, 8));
            srcmd_table = '0;
            srcmd_table[0].en.md = 31'($urandom_range(0, 3));
            srcmd_table[1].en.md = 31'($urandom_range(0, 3));
            m_arr = 12'($urandom);
            if ($urandom_range(0, 1) != 0) m_arr = m_arr & 12'($urandom);
            a_arr = 12'($urandom);
            s = $urandom_range(0, 3);
            p = $urandom_range(0, 10);
            en = $urandom_range(0, 7) != 0;
            hold = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0: a = rv_iopmp_pkg::ACCESS_NONE;
                1: a = rv_iopmp_pkg::ACCESS_READ;
                2: a = rv_iopmp_pkg::ACCESS_WRITE;
                default: a = rv_iopmp_pkg::ACCESS_EXECUTION;
            endcase
            run_txn("random", s, a, en, p, hold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv_iopmp_dl_multicycle.md
Name: rv_iopmp_dl_multicycle

Overview:
- Sequential successor to the combinational IOPMP decision logic.
- Accepts one transaction check per request handshake. Sweeps all NUMBER_ENTRIES entries in windows of NUMBER_ENTRY_ANALYZERS, driving the window offset to the external entry analyzers.
- Accumulates per-window results and resolves priority (first-match) and non-priority (any-allow) entries.
- Returns one registered allow/error response per request. Sits between the IOPMP transaction front end and the entry analyzer array.

Parameters:
- SID_WIDTH, 8, source ID width.
- NUMBER_MDS, 2, memory domains (1..63).
- NUMBER_ENTRIES, 8, total entries (>= NUMBER_ENTRY_ANALYZERS; need not be a multiple of it).
- NUMBER_MASTERS, 2, valid SIDs are 0..NUMBER_MASTERS-1.
- NUMBER_ENTRY_ANALYZERS, 4, entries evaluated per cycle (window size N).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- enable_i  in  1  IOPMP enable, sampled at request acceptance
- req_valid_i  in  1  check request valid
- req_ready_o  out  1  block can accept a request
- sid_i  in  SID_WIDTH  transaction source ID
- access_type_i  in  rv_iopmp_pkg::access_t  transaction access type
- prio_entry_i  in  16  entries with index < prio_entry_i are priority entries
- srcmd_table_i  in  rv_iopmp_pkg::srcmd_entry_t[NUMBER_MASTERS]  SRCMD table
- mdcfg_table_i  in  rv_iopmp_pkg::mdcfg_entry_t[NUMBER_MDS]  MDCFG top-index table
- entry_offset_o  out  16  base index of the current window, to the analyzers
- entry_match_i  in  N  per-analyzer match, combinational on entry_offset_o
- entry_allow_i  in  N  per-analyzer permission OK
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- allow_o  out  1  transaction allowed
- err_o  out  1  transaction flagged as error
- err_type_o  out  3  1 read, 2 write, 3 exec, 5 no-hit, 6 unknown SID, 7 other
- err_entry_index_o  out  16  index of the denying entry, else 0

Behaviour:
- Reset: all of the following clear to 0, state IDLE:
  - outputs: rsp_valid_o, allow_o, err_o, err_type_o, err_entry_index_o, entry_offset_o
  - internal registers: allow_seen, deny_seen, deny_idx
  - req_ready_o goes to 1.
- Reset in any state aborts the current check. No response is produced for the aborted request.
- States: IDLE, SCAN, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o, latch sid, access_type, enable and prio_entry. Clear allow_seen, deny_seen and deny_idx; set entry_offset_o=0.
  - If enable=0: load response allow=1, err=0 (bypass) and go to RESP.
  - Else if sid >= NUMBER_MASTERS: load err=1, type=6, allow=0 and go to RESP.
  - Else go to SCAN.
- SCAN (one window per cycle, base = entry_offset_o):
  - For analyzer j: idx = base + j. Entry j is valid when idx < NUMBER_ENTRIES.
  - Entry j is owned when idx lies in MD k, i.e. lo_k <= idx < mdcfg_table_i[k].t, with lo_0 = 0 and lo_k = mdcfg_table_i[k-1].t, and bit k of {srcmd_table_i[sid].enh, srcmd_table_i[sid].en.md} is 1.
  - Eligible = match & valid & owned. Let e = the lowest eligible j.
  - If e exists and idx(e) < prio_entry:
    - Decide immediately.
    - Allow bit set: allow=1.
    - Allow bit clear: err=1, err_entry_index=idx(e), type = access read→1, write→2, exec→3, others→7.
    - Go to RESP.
  - Otherwise, over the eligible non-priority entries of the window:
    - Any allow sets allow_seen.
    - The first deny, when deny_seen=0, records deny_idx and sets deny_seen.
  - If allow_seen is now set: load allow=1 and go to RESP (early termination).
  - Else if base + N >= NUMBER_ENTRIES (last window):
    - deny_seen set: err with deny_idx and the access-type code.
    - Otherwise: err type 5 (no hit).
    - Go to RESP.
  - Else entry_offset_o += N and stay in SCAN.
- RESP:
  - rsp_valid_o=1; response outputs are registered and held stable.
  - On rsp_ready_i, clear rsp_valid_o and return to IDLE.
  - req_ready_o=0 in RESP; there is no same-cycle re-accept.
- Latency, request accepted at cycle t:
  - Bypass or bad SID: rsp_valid_o at t+1.
  - Scan decided in window w (0-based): rsp_valid_o at t+2+w.
  - Maximum is t+1+ceil(NUMBER_ENTRIES/N).
- Changes to enable_i and the tables during SCAN are not re-sampled, except that the tables are read live each cycle; software must not modify them mid-check.
- Response values when err=1: allow=0. When allow=1: err=0, err_type=0, err_entry_index=0.

Test Plan:
Common setup: NUMBER_ENTRIES=8, N=4, mdcfg t = {4, 8}, SID0 enables MD0 (bits 0b01), SID1 enables MD1 (bits 0b10), prio_entry=8 unless stated.
- SID0, entry 2 match+allow -> allow_o=1, err_o=0, rsp_valid_o 2 cycles after accept, entry_offset_o never leaves 0.
- SID0 read, entry 1 match, allow=0 -> err_o=1, err_type_o=1, err_entry_index_o=1, decided in window 0.
- SID1, only entry 2 matches (belongs to MD0) -> both windows scanned, err_o=1, err_type_o=5, rsp_valid_o at t+3.
- prio_entry=4, SID1 write:
  - entry 5 deny and entry 6 allow -> allow_o=1.
  - entry 5 deny only -> err_type_o=2, err_entry_index_o=5.
- sid_i=2 -> err_type_o=6 at t+1. enable_i=0 -> allow_o=1, err_o=0 at t+1.
- Backpressure and reset:
  - rsp_ready_i held low 3 cycles -> outputs stable, req_ready_o=0.
  - rst_i asserted during SCAN -> next cycle state IDLE, rsp_valid_o=0, entry_offset_o=0, req_ready_o=1.
